fetch_pair_stage: RTL and testbench
===================================

# fetch_pair_stage

Dual-lane fetch stage and IF/ID pipeline register for the 2-wide superscalar MIPS core. It holds the PC and presents one aligned fetch address to instruction memory, which returns two words. It captures those words into lane-1/lane-2 IF/ID registers under the stall, flush and swap controls produced by the decode-stage controller. It also supplies the controller with registered IF/ID predecode (reg-write, mem-read, write register) and the `isBub` flag.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `NOP_WORD`, default 32'h0000_0000: instruction word inserted by flushes.

Ports, one per line (name, direction, width, meaning):
- `clk` in 1: single clock; every register updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `pc_en` in 1: 1 = PC may update this cycle; 0 = PC holds.
- `pc_src` in 1: redirect; when `pc_en`=1, PC loads `target`.
- `target` in 32: redirect address (branch, j, jal, jr).
- `swp` in 1: single-issue slip; lane-2 instruction moves to lane 1.
- `if_id_en_p1`, `if_id_en_p2` in 1 each: per-lane IF/ID load enables.
- `flush_p1_inst`, `flush_p1_pc`, `flush_p2` in 1 each: flush lane-1 instruction, lane-1 pc4, and lane 2.
- `imem_addr` out 32: equals the PC register.
- `imem_inst_p1`, `imem_inst_p2` in 32 each: words at PC and PC+4, combinational from memory.
- `inst_p1`, `inst_p2` out 32 each: IF/ID instruction registers.
- `pc4_p1`, `pc4_p2` out 32 each: IF/ID PC+4 registers.
- `isBub` out 1: lane 2 of IF/ID holds a flush bubble.
- `reg_write_p1`, `reg_write_p2` out 1 each: predecoded register write.
- `memread_p2` out 1: lane 2 is lw.
- `rw_p1`, `rw_p2` out 5 each: predecoded destination register.

## Operation
Internal state:
- `PC`
- Per lane: inst, pc4 and a valid bit.
- `isBub`

Reset (`rst`=0, asynchronous):
- PC = `RESET_PC`.
- inst = `NOP_WORD`, pc4 = 0 and valid = 0 in both lanes.
- `isBub` = 0.
- All predecode outputs read 0.

PC update, applied only when `pc_en`=1; the priority is `pc_src` > `swp` > normal:
- `pc_src`=1: PC = {`target`[31:2], 2'b00}.
- `swp`=1: PC = PC+4.
- Otherwise: PC = PC+8.
- Arithmetic is modulo 2^32, so 32'hFFFF_FFF8 + 8 wraps to 0.

Lane 1, priority top-down:
- Flush: `flush_p1_inst` sets inst = `NOP_WORD` and valid = 0. `flush_p1_pc` sets pc4 = 0. Each flush bit acts independently and overrides the load for its field.
- Load when `if_id_en_p1`=1:
  - `swp`=0: inst = `imem_inst_p1`, pc4 = PC+4, valid = 1.
  - `swp`=1: inst, pc4 and valid take the current lane-2 contents.
- Otherwise: hold.

Lane 2, priority top-down:
- `flush_p2`: inst = `NOP_WORD`, valid = 0, `isBub` = 1.
- Load when `if_id_en_p2`=1:
  - `swp`=0: inst = `imem_inst_p2`, pc4 = PC+8.
  - `swp`=1: inst = `imem_inst_p1`, pc4 = PC+4.
  - In both cases valid = 1 and `isBub` = 0.
- Otherwise: hold, including `isBub`.

Predecode is combinational from the registered lane contents:
- opcode 0 (R-type): reg_write = 1, rw = rd[15:11].
- lw (6'b100011), addi, addiu, slti, sltiu, andi, ori, xori, lui: reg_write = 1, rw = rt[20:16].
- jal (6'b000011): reg_write = 1, rw = 31.
- R-type jr (func 6'b001000): reg_write = 0.
- R-type jalr (func 6'b001001): reg_write = 1, rw = 31.
- sw, beq, bne, j and any other opcode: reg_write = 0, rw = 0.
- `memread_p2` = (lane-2 opcode == lw).
- A lane with valid = 0 forces reg_write = 0 and memread = 0, so the bubble word 0 (`sll $0`) creates no hazard.

## Timing
- Fetch-to-IF/ID latency is 1 cycle. Words presented with PC=A appear on `inst_p*` after the next rising edge.
- `imem_addr` and all `inst`, `pc4` and `isBub` outputs are registered.
- Predecode outputs are combinational from registers only. There is no input-to-output combinational path, so there is no loop through the controller.
- Simultaneous events:
  - A flush and the load enable of the same lane: the flush wins.
  - `swp` with `if_id_en_p1`=0: lane 1 holds and lane 2 obeys its own enable.
  - `pc_en`=0 with `if_id_en`=1: the lanes reload the same words (legal).
- Reset asserted mid-cycle clears all state immediately. After deassertion, the first edge fetches from `RESET_PC`.

## Test plan
- **Reset:** run, then pulse `rst`=0 mid-cycle → `imem_addr`=0, `inst_p1`=`inst_p2`=0, `isBub`=0, `reg_write_p1`=`reg_write_p2`=0, all immediately, without waiting for `clk`.
- **Normal fetch:** PC=0, imem={32'h8C08_0004, 32'h0109_4020}, all enables 1 → next cycle `inst_p1`=32'h8C08_0004, `pc4_p1`=4, `pc4_p2`=8, `rw_p1`=8, `rw_p2`=8, `reg_write_p1`=`reg_write_p2`=1, `memread_p2`=0, `imem_addr`=8.
- **Swap:** lane 2 = lw with `pc4_p2`=8, PC=8, `swp`=1, enables 1 → lane 1 = that lw with `pc4_p1`=8, `inst_p2`=`imem_inst_p1` with `pc4_p2`=12, PC=12.
- **Redirect and flush:** `pc_src`=1, `target`=32'h0000_0043, `flush_p1_inst`=`flush_p1_pc`=`flush_p2`=1 → PC=32'h40, both instructions 0, `pc4_p1`=0, `isBub`=1, `reg_write_p1`=`reg_write_p2`=0. `isBub` clears on the next lane-2 load.
- **Stall:** `pc_en`=0 and both `if_id_en`=0 for 3 cycles → PC, instructions, pc4 values and `isBub` are unchanged.
- **Conflict, jal and wrap:** `flush_p2`=1 with `if_id_en_p2`=1 → flush wins. A jal in lane 1 → `rw_p1`=31. PC=32'hFFFF_FFF8 with a normal advance → PC=0.

Source files
------------

// File: rtl/fetch_pair_stage.sv
// Dual-lane fetch stage with IF/ID pipeline register for the 2-wide MIPS core.
// Holds the PC, captures the fetched word pair, and predecodes both lanes for the hazard controller.
module fetch_pair_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_en,
  input  logic        pc_src,
  input  logic [31:0] target,
  input  logic        swp,
  input  logic        if_id_en_p1,
  input  logic        if_id_en_p2,
  input  logic        flush_p1_inst,
  input  logic        flush_p1_pc,
  input  logic        flush_p2,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst_p1,
  input  logic [31:0] imem_inst_p2,
  output logic [31:0] inst_p1,
  output logic [31:0] inst_p2,
  output logic [31:0] pc4_p1,
  output logic [31:0] pc4_p2,
  output logic        isBub,
  output logic        reg_write_p1,
  output logic        reg_write_p2,
  output logic        memread_p2,
  output logic [4:0]  rw_p1,
  output logic [4:0]  rw_p2
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst1_q, inst1_d, pc41_q, pc41_d;
  logic [31:0] inst2_q, inst2_d, pc42_q, pc42_d;
  logic        valid1_q, valid1_d, valid2_q, valid2_d;
  logic        bub_q, bub_d;
  logic [5:0]  pre1, pre2;

  // Redirect target is forced word-aligned by masking its low two bits.
  always_comb begin
    pc_d = pc_q;
    if (pc_en) begin
      if (pc_src)   pc_d = target & 32'hFFFF_FFFC;
      else if (swp) pc_d = pc_q + 32'd4;
      else          pc_d = pc_q + 32'd8;
    end
  end

  always_comb begin
    inst1_d  = inst1_q;
    pc41_d   = pc41_q;
    valid1_d = valid1_q;
    if (if_id_en_p1) begin
      if (swp) begin
        inst1_d  = inst2_q;
        pc41_d   = pc42_q;
        valid1_d = valid2_q;
      end else begin
        inst1_d  = imem_inst_p1;
        pc41_d   = pc_q + 32'd4;
        valid1_d = 1'b1;
      end
    end
    if (flush_p1_inst) begin
      inst1_d  = NOP_WORD;
      valid1_d = 1'b0;
    end
    if (flush_p1_pc) pc41_d = 32'd0;
  end

  // A lane-2 flush keeps the old pc4; only the instruction becomes a bubble.
  always_comb begin
    inst2_d  = inst2_q;
    pc42_d   = pc42_q;
    valid2_d = valid2_q;
    bub_d    = bub_q;
    if (flush_p2) begin
      inst2_d  = NOP_WORD;
      valid2_d = 1'b0;
      bub_d    = 1'b1;
    end else if (if_id_en_p2) begin
      inst2_d  = swp ? imem_inst_p1 : imem_inst_p2;
      pc42_d   = swp ? (pc_q + 32'd4) : (pc_q + 32'd8);
      valid2_d = 1'b1;
      bub_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      inst1_q  <= NOP_WORD;
      pc41_q   <= 32'd0;
      valid1_q <= 1'b0;
      inst2_q  <= NOP_WORD;
      pc42_q   <= 32'd0;
      valid2_q <= 1'b0;
      bub_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      inst1_q  <= inst1_d;
      pc41_q   <= pc41_d;
      valid1_q <= valid1_d;
      inst2_q  <= inst2_d;
      pc42_q   <= pc42_d;
      valid2_q <= valid2_d;
      bub_q    <= bub_d;
    end
  end

  // Returns {reg_write, rw}; an invalid lane reports nothing so bubbles never look like hazards.
  function automatic logic [5:0] predecode(input logic [31:0] inst, input logic valid);
    logic       we;
    logic [4:0] rw;
    we = 1'b0;
    rw = 5'd0;
    case (inst[31:26])
      OP_RTYPE: begin
        if (inst[5:0] == FN_JALR) begin
          we = 1'b1;
          rw = 5'd31;
        end else if (inst[5:0] != FN_JR) begin
          we = 1'b1;
          rw = inst[15:11];
        end
      end
      OP_LW, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        we = 1'b1;
        rw = inst[20:16];
      end
      OP_JAL: begin
        we = 1'b1;
        rw = 5'd31;
      end
      default: begin
        we = 1'b0;
        rw = 5'd0;
      end
    endcase
    return valid ? {we, rw} : 6'd0;
  endfunction

  always_comb begin
    pre1 = predecode(inst1_q, valid1_q);
    pre2 = predecode(inst2_q, valid2_q);
  end

  assign imem_addr    = pc_q;
  assign inst_p1      = inst1_q;
  assign inst_p2      = inst2_q;
  assign pc4_p1       = pc41_q;
  assign pc4_p2       = pc42_q;
  assign isBub        = bub_q;
  assign reg_write_p1 = pre1[5];
  assign rw_p1        = pre1[4:0];
  assign reg_write_p2 = pre2[5];
  assign rw_p2        = pre2[4:0];
  assign memread_p2   = valid2_q && (inst2_q[31:26] == OP_LW);

endmodule

// File: tb/tb_fetch_pair_stage.sv
// Bench for fetch_pair_stage: directed vector table, async reset check,
// then randomized traffic against a behavioural model of the fetch register.
module tb_fetch_pair_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_en, pc_src, swp, if_id_en_p1, if_id_en_p2;
  logic        flush_p1_inst, flush_p1_pc, flush_p2;
  logic [31:0] target, imem_inst_p1, imem_inst_p2;
  logic [31:0] imem_addr, inst_p1, inst_p2, pc4_p1, pc4_p2;
  logic        isBub, reg_write_p1, reg_write_p2, memread_p2;
  logic [4:0]  rw_p1, rw_p2;

  int total = 0;
  int bad = 0;

  fetch_pair_stage dut (
    .clk(clk), .rst(rst), .pc_en(pc_en), .pc_src(pc_src), .target(target), .swp(swp),
    .if_id_en_p1(if_id_en_p1), .if_id_en_p2(if_id_en_p2),
    .flush_p1_inst(flush_p1_inst), .flush_p1_pc(flush_p1_pc), .flush_p2(flush_p2),
    .imem_addr(imem_addr), .imem_inst_p1(imem_inst_p1), .imem_inst_p2(imem_inst_p2),
    .inst_p1(inst_p1), .inst_p2(inst_p2), .pc4_p1(pc4_p1), .pc4_p2(pc4_p2), .isBub(isBub),
    .reg_write_p1(reg_write_p1), .reg_write_p2(reg_write_p2), .memread_p2(memread_p2),
    .rw_p1(rw_p1), .rw_p2(rw_p2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pc_en, pc_src;
    logic [31:0] target;
    logic        swp, en1, en2, f1i, f1p, f2;
    logic [31:0] im1, im2;
    logic [31:0] e_addr, e_inst1, e_pc41, e_inst2, e_pc42;
    logic        e_bub, e_we1;
    logic [4:0]  e_rw1;
    logic        e_we2;
    logic [4:0]  e_rw2;
    logic        e_mr2;
  } vec_t;

  vec_t vecs[12];

  // Behavioural model state
  logic [31:0] m_pc, m_i1, m_p1, m_i2, m_p2;
  logic        m_v1, m_v2, m_b;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] addr, input logic [31:0] i1,
                             input logic [31:0] p1, input logic [31:0] i2, input logic [31:0] p2,
                             input logic bub, input logic we1, input logic [4:0] rw1,
                             input logic we2, input logic [4:0] rw2, input logic mr2);
    checkVal({tag, " imem_addr"}, imem_addr, addr);
    checkVal({tag, " inst_p1"}, inst_p1, i1);
    checkVal({tag, " pc4_p1"}, pc4_p1, p1);
    checkVal({tag, " inst_p2"}, inst_p2, i2);
    checkVal({tag, " pc4_p2"}, pc4_p2, p2);
    checkVal({tag, " isBub"}, {31'd0, isBub}, {31'd0, bub});
    checkVal({tag, " reg_write_p1"}, {31'd0, reg_write_p1}, {31'd0, we1});
    checkVal({tag, " rw_p1"}, {27'd0, rw_p1}, {27'd0, rw1});
    checkVal({tag, " reg_write_p2"}, {31'd0, reg_write_p2}, {31'd0, we2});
    checkVal({tag, " rw_p2"}, {27'd0, rw_p2}, {27'd0, rw2});
    checkVal({tag, " memread_p2"}, {31'd0, memread_p2}, {31'd0, mr2});
  endtask

  task automatic applyStimulus(input logic pe, input logic ps, input logic [31:0] tg,
                               input logic sw, input logic e1, input logic e2,
                               input logic fi, input logic fp, input logic f2,
                               input logic [31:0] w1, input logic [31:0] w2);
    pc_en = pe; pc_src = ps; target = tg; swp = sw;
    if_id_en_p1 = e1; if_id_en_p2 = e2;
    flush_p1_inst = fi; flush_p1_pc = fp; flush_p2 = f2;
    imem_inst_p1 = w1; imem_inst_p2 = w2;
  endtask

  // Destination-register rules of the MIPS subset, stated per instruction class
  task automatic modelPredecode(input logic [31:0] w, input logic valid,
                                output logic we, output logic [4:0] rw);
    int op, fn;
    op = int'(w[31:26]);
    fn = int'(w[5:0]);
    we = 1'b0;
    rw = 5'd0;
    if (valid) begin
      if (op == 0 && fn == 9) begin we = 1'b1; rw = 5'd31; end
      else if (op == 0 && fn != 8) begin we = 1'b1; rw = w[15:11]; end
      else if (op == 35 || (op >= 8 && op <= 15)) begin we = 1'b1; rw = w[20:16]; end
      else if (op == 3) begin we = 1'b1; rw = 5'd31; end
    end
  endtask

  task automatic modelReset();
    m_pc = 32'd0; m_i1 = 32'd0; m_p1 = 32'd0; m_v1 = 1'b0;
    m_i2 = 32'd0; m_p2 = 32'd0; m_v2 = 1'b0; m_b = 1'b0;
  endtask

  // Advance the model by one edge using the inputs currently driven
  task automatic modelStep();
    logic [31:0] npc, ni1, np1, ni2, np2;
    logic nv1, nv2, nb;
    npc = m_pc; ni1 = m_i1; np1 = m_p1; nv1 = m_v1;
    ni2 = m_i2; np2 = m_p2; nv2 = m_v2; nb = m_b;
    if (pc_en) npc = pc_src ? (target / 4) * 4 : m_pc + (swp ? 4 : 8);
    if (if_id_en_p1 && swp) begin ni1 = m_i2; np1 = m_p2; nv1 = m_v2; end
    else if (if_id_en_p1) begin ni1 = imem_inst_p1; np1 = m_pc + 4; nv1 = 1'b1; end
    if (flush_p1_inst) begin ni1 = 32'd0; nv1 = 1'b0; end
    if (flush_p1_pc) np1 = 32'd0;
    if (flush_p2) begin ni2 = 32'd0; nv2 = 1'b0; nb = 1'b1; end
    else if (if_id_en_p2) begin
      ni2 = swp ? imem_inst_p1 : imem_inst_p2;
      np2 = m_pc + (swp ? 4 : 8);
      nv2 = 1'b1; nb = 1'b0;
    end
    @(posedge clk);
    #1;
    m_pc = npc; m_i1 = ni1; m_p1 = np1; m_v1 = nv1;
    m_i2 = ni2; m_p2 = np2; m_v2 = nv2; m_b = nb;
  endtask

  function automatic logic [31:0] randomWord();
    logic [5:0] ops[16];
    logic [31:0] w;
    ops = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h03, 6'h2B, 6'h04, 6'h02};
    w = $urandom;
    w[31:26] = ops[$urandom_range(0, 15)];
    if (w[31:26] == 6'h00 && $urandom_range(0, 3) == 0) w[5:0] = $urandom_range(0, 1) ? 6'h08 : 6'h09;
    return w;
  endfunction

  initial begin
    logic we1, we2, mr2;
    logic [4:0] rw1, rw2;

    vecs[0]  = '{1,0,32'h0, 0,1,1,0,0,0, 32'h8C08_0004,32'h0109_4020, 32'h8,
                 32'h8C08_0004,32'h4, 32'h0109_4020,32'h8, 0, 1,5'd8, 1,5'd8, 0};
    vecs[1]  = '{1,0,32'h0, 1,1,1,0,0,0, 32'h8C0A_0010,32'hFFFF_FFFF, 32'hC,
                 32'h0109_4020,32'h8, 32'h8C0A_0010,32'hC, 0, 1,5'd8, 1,5'd10, 1};
    vecs[2]  = '{1,1,32'h43, 0,1,1,1,1,1, 32'h1234_5678,32'h9ABC_DEF0, 32'h40,
                 32'h0,32'h0, 32'h0,32'hC, 1, 0,5'd0, 0,5'd0, 0};
    vecs[3]  = '{1,0,32'h0, 0,1,1,0,0,0, 32'h0C00_0010,32'hAC0B_0000, 32'h48,
                 32'h0C00_0010,32'h44, 32'hAC0B_0000,32'h48, 0, 1,5'd31, 0,5'd0, 0};
    vecs[4]  = '{0,0,32'h0, 0,0,0,0,0,0, 32'hDEAD_BEEF,32'hCAFE_F00D, 32'h48,
                 32'h0C00_0010,32'h44, 32'hAC0B_0000,32'h48, 0, 1,5'd31, 0,5'd0, 0};
    vecs[5]  = '{0,1,32'h100, 0,0,0,0,0,0, 32'h8C01_0000,32'h8C02_0000, 32'h48,
                 32'h0C00_0010,32'h44, 32'hAC0B_0000,32'h48, 0, 1,5'd31, 0,5'd0, 0};
    vecs[6]  = '{0,0,32'h0, 1,0,0,0,0,0, 32'h2003_0001,32'h2004_0001, 32'h48,
                 32'h0C00_0010,32'h44, 32'hAC0B_0000,32'h48, 0, 1,5'd31, 0,5'd0, 0};
    vecs[7]  = '{1,0,32'h0, 0,0,1,0,0,1, 32'h8C0C_0000,32'h8C0D_0000, 32'h50,
                 32'h0C00_0010,32'h44, 32'h0,32'h48, 1, 1,5'd31, 0,5'd0, 0};
    vecs[8]  = '{1,0,32'h0, 1,0,1,0,0,0, 32'h03E0_0008,32'h1111_1111, 32'h54,
                 32'h0C00_0010,32'h44, 32'h03E0_0008,32'h54, 0, 1,5'd31, 0,5'd0, 0};
    vecs[9]  = '{1,0,32'h0, 0,1,1,0,1,0, 32'h0000_F809,32'h3C0E_1234, 32'h5C,
                 32'h0000_F809,32'h0, 32'h3C0E_1234,32'h5C, 0, 1,5'd31, 1,5'd14, 0};
    vecs[10] = '{1,1,32'hFFFF_FFFB, 0,1,1,0,0,0, 32'h8C0F_0000,32'h0, 32'hFFFF_FFF8,
                 32'h8C0F_0000,32'h60, 32'h0,32'h64, 0, 1,5'd15, 1,5'd0, 0};
    vecs[11] = '{1,0,32'h0, 0,1,1,0,0,0, 32'h2810_FFFF,32'h8C11_0000, 32'h0,
                 32'h2810_FFFF,32'hFFFF_FFFC, 32'h8C11_0000,32'h0, 0, 1,5'd16, 1,5'd17, 1};

    applyStimulus(0,0,0, 0,0,0,0,0,0, 0,0);
    rst = 1'b0;
    #1;
    checkOutput("initial reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Enables were low on that edge, so the state is still the reset state
    checkOutput("idle after reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].pc_en, vecs[i].pc_src, vecs[i].target, vecs[i].swp,
                    vecs[i].en1, vecs[i].en2, vecs[i].f1i, vecs[i].f1p, vecs[i].f2,
                    vecs[i].im1, vecs[i].im2);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_inst1, vecs[i].e_pc41,
                  vecs[i].e_inst2, vecs[i].e_pc42, vecs[i].e_bub, vecs[i].e_we1, vecs[i].e_rw1,
                  vecs[i].e_we2, vecs[i].e_rw2, vecs[i].e_mr2);
    end

    // Load a distinctive state, then pull reset low between clock edges
    applyStimulus(1,1,32'h200, 0,1,1,0,0,0, 32'h8C05_0000, 32'h8C06_0000);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midcycle reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    applyStimulus(0,0,0, 0,0,0,0,0,0, 0,0);
    rst = 1'b1;
    modelReset();

    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, $urandom,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                    randomWord(), randomWord());
      modelStep();
      modelPredecode(m_i1, m_v1, we1, rw1);
      modelPredecode(m_i2, m_v2, we2, rw2);
      mr2 = m_v2 && (m_i2[31:26] == 6'b100011);
      checkOutput($sformatf("rand%0d", c), m_pc, m_i1, m_p1, m_i2, m_p2, m_b,
                  we1, rw1, we2, rw2, mr2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
